// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: one full-adder cell time-shared over WIDTH clocks, with start/done handshake.
// Optional feature macro: SERIAL_ADD_SUB_EN adds a sub input that turns the operation into a-b.
module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef SERIAL_ADD_SUB_EN
    ,
    input  logic             sub
`endif
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res_sr;
    logic [WIDTH-1:0] sum_r;
    logic             carry;
    logic             cout_r;
    logic [CNT_W-1:0] cnt;
    logic             accept;
    logic             last;
    logic             fa_s;
    logic             fa_cout;
    logic [WIDTH-1:0] b_load;
    logic             carry_load;

    // The single full-adder cell shared by every bit position.
    always_comb begin
        fa_s    = a_sr[0] ^ b_sr[0] ^ carry;
        fa_cout = (a_sr[0] & b_sr[0]) | (carry & (a_sr[0] ^ b_sr[0]));
    end

`ifdef SERIAL_ADD_SUB_EN
    // Two's-complement subtract: invert B and force the initial carry.
    assign b_load     = sub ? ~b : b;
    assign carry_load = sub ? 1'b1 : cin;
`else
    assign b_load     = b;
    assign carry_load = cin;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        ready     = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        accept    = 1'b0;
        last      = 1'b0;
        case (state)
            IDLE: begin
                ready = 1'b1;
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                busy = 1'b1;
                if (cnt == CNT_LAST) begin
                    last      = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Result is captured on the final shift so sum/cout stay stable while the next operation runs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_sr   <= '0;
            b_sr   <= '0;
            res_sr <= '0;
            sum_r  <= '0;
            carry  <= 1'b0;
            cout_r <= 1'b0;
            cnt    <= '0;
        end else if (accept) begin
            a_sr  <= a;
            b_sr  <= b_load;
            carry <= carry_load;
            cnt   <= '0;
        end else if (busy) begin
            a_sr   <= a_sr >> 1;
            b_sr   <= b_sr >> 1;
            res_sr <= {fa_s, res_sr[WIDTH-1:1]};
            carry  <= fa_cout;
            if (last) begin
                cnt    <= '0;
                sum_r  <= {fa_s, res_sr[WIDTH-1:1]};
                cout_r <= fa_cout;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign sum  = sum_r;
    assign cout = cout_r;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Scoreboard bench for serial_add_ctrl: stimulus pushes expected {cout,sum}, a monitor checks each done pulse.
module tb_serial_add_ctrl;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         ready;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
`ifdef SERIAL_ADD_SUB_EN
    logic         sub;
`endif

    int n_vec = 0;
    int n_err = 0;
    logic [W:0] exp_q[$];

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .ready (ready),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
`ifdef SERIAL_ADD_SUB_EN
        ,
        .sub   (sub)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!reset && done) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 32'(done), 32'd0);
            end else begin
                logic [W:0] e;
                e = exp_q.pop_front();
                check("result", 32'({cout, sum}), 32'(e));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    // Called at a negedge; waits for ready, then applies one start pulse ending after the accept edge.
    task automatic issue(input logic [W-1:0] av, input logic [W-1:0] bv, input logic ci,
                         input logic sb, input logic [W:0] expv, input bit push);
        int t = 0;
        while (!ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (!ready) check("ready_wait", 32'(ready), 32'd1);
        a     = av;
        b     = bv;
        cin   = ci;
`ifdef SERIAL_ADD_SUB_EN
        sub   = sb;
`endif
        if (sb) check("sub_unsupported_build", 32'(sb), 32'd0);
        if (push) exp_q.push_back(expv);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Follows an operation from the accept edge through busy/done/ready timing.
    task automatic follow(input bit interfere);
        for (int k = 1; k <= W; k++) begin
            @(negedge clk);
            check("busy", 32'({busy, ready, done}), 32'b100);
            if (interfere && k == 3) begin
                a = 8'h01;
                b = 8'h01;
                start = 1'b1;
            end
            if (interfere && k == 6) start = 1'b0;
        end
        @(negedge clk);
        check("done_cycle", 32'({busy, ready, done}), 32'b001);
        @(negedge clk);
        check("ready_return", 32'({busy, ready, done}), 32'b010);
    endtask

    initial begin
        int dcnt;
        int dk[$];
        reset = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        cin   = 1'b0;
`ifdef SERIAL_ADD_SUB_EN
        sub   = 1'b0;
`endif
        #3;
        check("reset_ready", 32'(ready), 32'd1);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_sum", 32'(sum), 32'd0);
        check("reset_cout", 32'(cout), 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // 0x3C + 0x0F with start re-asserted mid-SHIFT using other operands
        issue(8'h3C, 8'h0F, 1'b0, 1'b0, 9'h04B, 1'b1);
        follow(1'b1);
        for (int k = 0; k < 3; k++) begin
            check("hold_sum", 32'({cout, sum}), 32'h04B);
            check("hold_ready", 32'(ready), 32'd1);
            @(negedge clk);
        end

        issue(8'hFF, 8'h01, 1'b0, 1'b0, 9'h100, 1'b1);
        follow(1'b0);
        issue(8'hFF, 8'h00, 1'b1, 1'b0, 9'h100, 1'b1);
        follow(1'b0);
        issue(8'hA5, 8'h5A, 1'b1, 1'b0, 9'h100, 1'b1);
        follow(1'b0);
        issue(8'h12, 8'h34, 1'b0, 1'b0, 9'h046, 1'b1);
        follow(1'b0);

        // Reset asserted at E0+4: outputs clear asynchronously, no done pulse
        issue(8'h55, 8'h66, 1'b0, 1'b0, 9'h0BB, 1'b0);
        repeat (4) @(negedge clk);
        check("pre_reset_sum", 32'(sum), 32'h46);
        reset = 1'b1;
        #1;
        check("async_ready", 32'(ready), 32'd1);
        check("async_busy", 32'(busy), 32'd0);
        check("async_sum", 32'(sum), 32'd0);
        check("async_cout", 32'(cout), 32'd0);
        check("async_done", 32'(done), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        dcnt = 0;
        for (int k = 0; k < W + 4; k++) begin
            @(negedge clk);
            if (done) dcnt++;
        end
        check("no_done_after_reset", 32'(dcnt), 32'd0);

        issue(8'h10, 8'h20, 1'b0, 1'b0, 9'h030, 1'b1);
        follow(1'b0);

        // start held high: back-to-back operations every W+2 cycles
        a     = 8'h80;
        b     = 8'h80;
        cin   = 1'b0;
        exp_q.push_back(9'h100);
        exp_q.push_back(9'h100);
        exp_q.push_back(9'h100);
        start = 1'b1;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (done) dk.push_back(k);
        end
        start = 1'b0;
        check("held_done_count", 32'(dk.size()), 32'd3);
        if (dk.size() == 3) begin
            check("held_spacing1", 32'(dk[1] - dk[0]), 32'(W + 2));
            check("held_spacing2", 32'(dk[2] - dk[1]), 32'(W + 2));
        end
        repeat (W + 4) @(negedge clk);
        check("held_idle", 32'(ready), 32'd1);

`ifdef SERIAL_ADD_SUB_EN
        issue(8'h05, 8'h07, 1'b0, 1'b1, 9'h0FE, 1'b1);
        follow(1'b0);
        issue(8'h07, 8'h05, 1'b0, 1'b1, 9'h102, 1'b1);
        follow(1'b0);
        issue(8'h3C, 8'h0F, 1'b1, 1'b0, 9'h04C, 1'b1);
        follow(1'b0);
`endif

        repeat (3) @(negedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/serial_add_ctrl.md
# serial_add_ctrl

Bit-serial adder controller that time-shares one single-bit full-adder cell (the existing Full_Adder) to add two WIDTH-bit operands over WIDTH clock cycles. It owns the operand shift registers, the carry flip-flop, the bit counter and a start/done handshake. Upstream logic, such as a switch/button front end, supplies operands; the result drives the display or the next lab stage.

## Interface
Parameters:
- WIDTH, 8, operand/result width in bits; legal range 2..32.

Ports:
- clk  in  1  system clock, rising-edge active.
- reset  in  1  asynchronous, active-high; clears all state.
- start  in  1  request pulse or level; sampled only in IDLE.
- a  in  WIDTH  operand A; sampled on the accepting edge.
- b  in  WIDTH  operand B; sampled on the accepting edge.
- cin  in  1  carry-in; sampled on the accepting edge.
- ready  out  1  high in IDLE only.
- busy  out  1  high in SHIFT only.
- done  out  1  one-cycle pulse in DONE; result valid.
- sum  out  WIDTH  result; holds until the next accepted start.
- cout  out  1  final carry-out; holds with sum.
- sub  in  1  present only with SERIAL_ADD_SUB_EN; sampled with a/b.

## Operation
- FSM states: IDLE, SHIFT, DONE. Encoding is free. Reset state is IDLE.
- IDLE:
  - ready=1.
  - If start=1 at the edge: a_sr<=a, b_sr<=b, carry<=cin, cnt<=0, then go to SHIFT.
  - sum/cout keep their previous values.
- SHIFT: every edge:
  - Feed a_sr[0], b_sr[0] and carry into the full-adder cell.
  - res_sr<={S, res_sr[WIDTH-1:1]}, so the LSB result lands at bit 0 after WIDTH shifts.
  - a_sr/b_sr shift right. carry<=Cout. cnt<=cnt+1.
  - When cnt==WIDTH-1, the edge performs the final shift and the FSM goes to DONE.
- DONE:
  - done=1 for exactly one cycle.
  - sum=res_sr, cout=carry; both registered and stable.
  - Unconditionally returns to IDLE.
- start is ignored in SHIFT and DONE. There is no queuing; requesters must wait for ready.
- Arithmetic is modulo 2^WIDTH. {cout,sum} = a + b + cin exactly.
- cnt width is $clog2(WIDTH+1). cnt never exceeds WIDTH-1.
- Exactly one full-adder instance exists. No parallel carry logic is allowed.

## Timing
- Reset values: ready=1, busy=0, done=0, sum=0, cout=0. All internal registers are 0 and the state is IDLE.
- Accept edge E0: start=1 while ready=1.
- busy is high for cycles E0+1 .. E0+WIDTH, i.e. WIDTH cycles.
- done is high in cycle E0+WIDTH+1. ready returns at E0+WIDTH+2.
- Start-to-done latency is WIDTH+1 clocks. Minimum issue interval is WIDTH+2 clocks.
- Holding start high continuously re-accepts on every IDLE cycle, giving back-to-back operations every WIDTH+2 clocks.
- Operand changes after E0 have no effect on the operation in flight.
- Asserting reset mid-SHIFT or in DONE:
  - Outputs go to their reset values immediately, without waiting for a clock.
  - No done pulse is produced.
- On reset deassertion, the first edge with start=1 is accepted normally.

## Configuration
- SERIAL_ADD_SUB_EN defined:
  - Adds the sub input port.
  - On accept with sub=1: b_sr<=~b and carry<=1, ignoring cin, so the result is a-b.
  - cout=1 means no borrow (a>=b unsigned).
  - With sub=0, behaviour is identical to the plain adder.
- SERIAL_ADD_SUB_EN undefined:
  - No sub port and no inverter logic.
  - The block is a pure adder as described above.

## Test plan
- Reset, then WIDTH=8, a=0x3C, b=0x0F, cin=0, start pulse at E0.
  - busy is high for 8 cycles.
  - done at E0+9 with sum=0x4B, cout=0.
  - ready at E0+10.
- Carry ripple: a=0xFF, b=0x01, cin=0 gives sum=0x00, cout=1. a=0xFF, b=0x00, cin=1 gives sum=0x00, cout=1.
- Start re-asserted during SHIFT with different operands (a=0x01, b=0x01).
  - Ignored; the first result 0x4B/0 is unchanged.
  - sum holds 0x4B through IDLE until the next accepted start.
- Reset asserted at E0+4 of an operation.
  - ready=1, busy=0, sum=0, cout=0 without a clock edge.
  - No done pulse.
  - The next operation, 0x10+0x20, yields 0x30 with cout=0.
- start held high for 30 cycles with a=0x80, b=0x80.
  - done pulses every 10 cycles.
  - Each pulse shows sum=0x00, cout=1.
- With SERIAL_ADD_SUB_EN: a=0x05, b=0x07, sub=1 gives sum=0xFE, cout=0. a=0x07, b=0x05, sub=1 gives sum=0x02, cout=1.
